// File: rtl/que_pkg.sv
// Shared definitions for the capture-side aggregator and the que_aiso serializer:
// default geometry and the chunk-counter width helper.
package que_pkg;

  localparam int DEF_ENQ_WIDTH = 32;
  localparam int DEF_CHUNKS    = 12;

  function automatic int cnt_width(input int chunks);
    return $clog2(chunks + 1);
  endfunction

  typedef logic [$clog2(DEF_CHUNKS + 1)-1:0] cnt_t;

endpackage

// File: rtl/que_aiso_if.sv
// Wide-in / narrow-out bus for que_aiso; the master side loads words and pops chunks.
interface que_aiso_if
  import que_pkg::*;
#(
  parameter int ENQ_WIDTH = DEF_ENQ_WIDTH,
  parameter int CHUNKS    = DEF_CHUNKS
);

  localparam int OUT_WIDTH = ENQ_WIDTH * CHUNKS;
  localparam int CW        = cnt_width(CHUNKS);

  logic [OUT_WIDTH-1:0] wdata;
  logic                 load;
  logic                 deque;
  logic [ENQ_WIDTH-1:0] rdata;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic                 err;

  modport master (output wdata, load, deque, input rdata, full, empty, count, err);
  modport slave  (input wdata, load, deque, output rdata, full, empty, count, err);

endinterface

// File: rtl/que_aiso.sv
// All-in, serial-out width converter: one wide word in, CHUNKS narrow chunks out, MSB first.
// Optional sticky misuse flag enabled by defining QUE_AISO_ERR_EN.
module que_aiso
  import que_pkg::*;
#(
  parameter int ENQ_WIDTH = DEF_ENQ_WIDTH,
  parameter int CHUNKS    = DEF_CHUNKS
) (
  input  logic       clk,
  input  logic       rst,
  que_aiso_if.slave  bus
);

  localparam int OUT_WIDTH = ENQ_WIDTH * CHUNKS;
  localparam int CW        = cnt_width(CHUNKS);
  localparam logic [CW-1:0] CNT_FULL = CW'(CHUNKS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [OUT_WIDTH-1:0] buffer_reg, buffer_next;
  logic [CW-1:0]        count_reg, count_next;
  logic                 is_empty;
  logic                 load_ok;
  logic                 pop_ok;

  // A load is only taken into an empty buffer, or as a same-cycle refill on the last pop.
  always_comb begin
    is_empty    = (count_reg == '0);
    load_ok     = bus.load && (is_empty || (count_reg == CNT_ONE && bus.deque));
    pop_ok      = bus.deque && !is_empty;
    buffer_next = buffer_reg;
    count_next  = count_reg;
    if (load_ok) begin
      buffer_next = bus.wdata;
      count_next  = CNT_FULL;
    end else if (pop_ok) begin
      buffer_next = buffer_reg << ENQ_WIDTH;
      count_next  = count_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer_reg <= '0;
      count_reg  <= '0;
    end else begin
      buffer_reg <= buffer_next;
      count_reg  <= count_next;
    end
  end

  assign bus.rdata = buffer_reg[OUT_WIDTH-1 -: ENQ_WIDTH];
  assign bus.empty = is_empty;
  assign bus.full  = (count_reg == CNT_FULL);
  assign bus.count = count_reg;

`ifdef QUE_AISO_ERR_EN
  logic err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if ((bus.load && !load_ok) || (bus.deque && is_empty)) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.err = err_reg;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_que_aiso.sv
// Self-checking bench for que_aiso: chunk-queue reference model, table vectors,
// hand-written corner sequences and an aggregator round trip.
module tb_que_aiso;
  import que_pkg::*;

  localparam int EW = 32;
  localparam int NC = 12;
  localparam int OW = EW * NC;
`ifdef QUE_AISO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  que_aiso_if #(.ENQ_WIDTH(EW), .CHUNKS(NC)) bus ();
  que_aiso #(.ENQ_WIDTH(EW), .CHUNKS(NC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the chunks still to be delivered, head first, plus the sticky flag.
  logic [EW-1:0] mq[$];
  bit            m_err = 1'b0;
  bit            cur_rst, cur_ld, cur_dq;
  logic [OW-1:0] cur_wd;

  typedef struct {
    bit          ld;
    bit          dq;
    logic [EW-1:0] rdata;
    int          count;
    bit          full;
    bit          empty;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(string name, logic [EW-1:0] act, logic [EW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Aggregator behaviour: each new chunk enters at the LSB, older ones move up.
  function automatic logic [OW-1:0] agg(input logic [EW-1:0] c[NC]);
    logic [OW-1:0] w = '0;
    for (int i = 0; i < NC; i++) w = (w << EW) | OW'(c[i]);
    return w;
  endfunction

  task automatic check_model(string tag);
    chk({tag, ".rdata"}, bus.rdata, (mq.size() > 0) ? mq[0] : '0);
    chk({tag, ".count"}, EW'(bus.count), EW'(mq.size()));
    chk({tag, ".empty"}, EW'(bus.empty), EW'(mq.size() == 0));
    chk({tag, ".full"},  EW'(bus.full),  EW'(mq.size() == NC));
    chk({tag, ".err"},   EW'(bus.err),   EW'(m_err));
  endtask

  task automatic begin_cyc(bit r, bit ld, bit dq, logic [OW-1:0] wd);
    rst = r; bus.load = ld; bus.deque = dq; bus.wdata = wd;
    cur_rst = r; cur_ld = ld; cur_dq = dq; cur_wd = wd;
    @(negedge clk);
  endtask

  task automatic end_cyc();
    bit acc;
    if (cur_rst) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      acc = cur_ld && (mq.size() == 0 || (mq.size() == 1 && cur_dq));
      if (ERR_EN && ((cur_ld && !acc) || (cur_dq && mq.size() == 0))) m_err = 1'b1;
      if (acc) begin
        mq.delete();
        for (int k = 0; k < NC; k++) mq.push_back(cur_wd[OW-1-k*EW -: EW]);
      end else if (cur_dq && mq.size() > 0) begin
        void'(mq.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(bit r, bit ld, bit dq, logic [OW-1:0] wd, string tag);
    begin_cyc(r, ld, dq, wd);
    check_model(tag);
    end_cyc();
  endtask

  function automatic logic [OW-1:0] rand_word();
    logic [OW-1:0] w = '0;
    for (int i = 0; i < NC; i++) w = (w << EW) | OW'($urandom);
    return w;
  endfunction

  initial begin
    logic [EW-1:0] ch[NC];
    logic [EW-1:0] exp_stream[$];
    logic [OW-1:0] w_cnt, w_a5, w5, wd;
    int words_left, out_cnt, budget;
    bit ld, dq;

    for (int i = 0; i < NC; i++) ch[i] = EW'(NC - 1 - i);
    w_cnt = agg(ch);
    for (int i = 0; i < NC; i++) ch[i] = 32'hA5A5_A5A5;
    w_a5 = agg(ch);

    tbl[0] = '{ld: 1'b1, dq: 1'b0, rdata: '0, count: 0, full: 1'b0, empty: 1'b1};
    for (int k = 1; k <= NC; k++)
      tbl[k] = '{ld: 1'b0, dq: 1'b1, rdata: EW'(NC - k), count: NC + 1 - k,
                 full: (k == 1), empty: 1'b0};
    tbl[13] = '{ld: 1'b0, dq: 1'b0, rdata: '0, count: 0, full: 1'b0, empty: 1'b1};

    // 1: reset with load and deque held high
    $display("test 1: reset");
    begin_cyc(1'b1, 1'b1, 1'b1, w_a5); end_cyc();
    begin_cyc(1'b1, 1'b1, 1'b1, w_a5); end_cyc();
    begin_cyc(1'b0, 1'b0, 1'b0, '0);
    chk("rst.rdata", bus.rdata, '0);
    chk("rst.count", EW'(bus.count), 0);
    chk("rst.empty", EW'(bus.empty), 1);
    chk("rst.full",  EW'(bus.full), 0);
    chk("rst.err",   EW'(bus.err), 0);
    end_cyc();

    // 2: table-driven load then 12 pops
    $display("test 2: load and drain counting word");
    for (int i = 0; i < 14; i++) begin
      begin_cyc(1'b0, tbl[i].ld, tbl[i].dq, w_cnt);
      chk($sformatf("vec%0d.rdata", i), bus.rdata, tbl[i].rdata);
      chk($sformatf("vec%0d.count", i), EW'(bus.count), EW'(tbl[i].count));
      chk($sformatf("vec%0d.full", i),  EW'(bus.full), EW'(tbl[i].full));
      chk($sformatf("vec%0d.empty", i), EW'(bus.empty), EW'(tbl[i].empty));
      check_model($sformatf("vec%0d", i));
      end_cyc();
    end

    // 3: refill on the last pop, no bubble
    $display("test 3: back-to-back refill");
    cyc(1'b0, 1'b1, 1'b0, w_cnt, "b2b.load");
    for (int k = 0; k < NC - 1; k++) cyc(1'b0, 1'b0, 1'b1, '0, "b2b.pop");
    begin_cyc(1'b0, 1'b1, 1'b1, w_a5);
    chk("b2b.last.count", EW'(bus.count), 1);
    chk("b2b.last.rdata", bus.rdata, 32'h0);
    end_cyc();
    begin_cyc(1'b0, 1'b0, 1'b0, '0);
    chk("b2b.count", EW'(bus.count), NC);
    chk("b2b.rdata", bus.rdata, 32'hA5A5_A5A5);
    chk("b2b.empty", EW'(bus.empty), 0);
    end_cyc();
    for (int k = 0; k < NC; k++) cyc(1'b0, 1'b0, 1'b1, '0, "b2b.drain");

    // 4: ignored load mid-word and ignored deque while empty
    $display("test 4: misuse");
    cyc(1'b0, 1'b1, 1'b0, w_cnt, "mis.load");
    for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0, 1'b1, '0, "mis.pop");
    begin_cyc(1'b0, 1'b1, 1'b0, w_a5); end_cyc();
    begin_cyc(1'b0, 1'b0, 1'b0, '0);
    chk("mis.ld.count", EW'(bus.count), 5);
    chk("mis.ld.rdata", bus.rdata, 32'h4);
    chk("mis.ld.err",   EW'(bus.err), EW'(ERR_EN));
    end_cyc();
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, '0, "mis.drain");
    begin_cyc(1'b0, 1'b0, 1'b1, '0); end_cyc();
    begin_cyc(1'b0, 1'b0, 1'b0, '0);
    chk("mis.dq.count", EW'(bus.count), 0);
    chk("mis.dq.rdata", bus.rdata, '0);
    chk("mis.dq.err",   EW'(bus.err), EW'(ERR_EN));
    end_cyc();
    cyc(1'b0, 1'b1, 1'b0, w_cnt, "mis.reload");
    for (int k = 0; k < NC; k++) cyc(1'b0, 1'b0, 1'b1, '0, "mis.pop2");
    begin_cyc(1'b0, 1'b0, 1'b0, '0);
    chk("mis.sticky.err", EW'(bus.err), EW'(ERR_EN));
    end_cyc();
    begin_cyc(1'b1, 1'b0, 1'b0, '0); end_cyc();
    begin_cyc(1'b0, 1'b0, 1'b0, '0);
    chk("mis.rst.err", EW'(bus.err), 0);
    end_cyc();

    // 5: reset mid-word, then a fresh word survives intact
    $display("test 5: reset mid-word");
    cyc(1'b0, 1'b1, 1'b0, w_cnt, "rmw.load");
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, '0, "rmw.pop");
    begin_cyc(1'b0, 1'b0, 1'b0, '0);
    chk("rmw.pre.count", EW'(bus.count), 7);
    end_cyc();
    begin_cyc(1'b1, 1'b0, 1'b0, '0); end_cyc();
    begin_cyc(1'b0, 1'b0, 1'b0, '0);
    chk("rmw.empty", EW'(bus.empty), 1);
    chk("rmw.rdata", bus.rdata, '0);
    chk("rmw.count", EW'(bus.count), 0);
    end_cyc();
    for (int i = 0; i < NC; i++) ch[i] = $urandom;
    w5 = agg(ch);
    cyc(1'b0, 1'b1, 1'b0, w5, "rmw.load2");
    for (int k = 0; k < NC; k++) begin
      begin_cyc(1'b0, 1'b0, 1'b1, '0);
      chk($sformatf("rmw.chunk%0d", k), bus.rdata, ch[k]);
      end_cyc();
    end

    // random load/deque traffic including misuse
    $display("random traffic: 400 cycles");
    for (int i = 0; i < 400; i++)
      cyc(1'b0, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, rand_word(), "rnd");

    // 6: aggregator round trip over 1000 random words
    $display("test 6: round trip 1000 words");
    cyc(1'b1, 1'b0, 1'b0, '0, "rt.rst");
    words_left = 1000;
    out_cnt    = 0;
    budget     = 0;
    while (out_cnt < 1000 * NC && budget < 40000) begin
      budget++;
      dq = ($urandom_range(0, 3) != 0);
      ld = (words_left > 0) && (mq.size() == 0 || (mq.size() == 1 && dq));
      wd = '0;
      if (ld) begin
        for (int i = 0; i < NC; i++) begin
          ch[i] = $urandom;
          exp_stream.push_back(ch[i]);
        end
        wd = agg(ch);
        words_left--;
      end
      begin_cyc(1'b0, ld, dq, wd);
      if (dq && bus.empty == 1'b0 && exp_stream.size() > 0) begin
        chk("rt.chunk", bus.rdata, exp_stream.pop_front());
        out_cnt++;
      end
      check_model("rt");
      end_cyc();
    end
    chk("rt.delivered", EW'(out_cnt), EW'(1000 * NC));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
